// File: rtl/ram1_arbiter.sv
// ram1_arbiter: grants the single-port RAM1 SRAM to either instruction fetch
// or in-range data accesses, and runs each access as a SETUP/HOLD pair.
// Optional build macro: RAM1_ARB_FAIR_EN selects round-robin arbitration
// (tracked with last_owner); otherwise MEM always beats IF.
//
// Handshake: a requester raises req with its address/data and holds all of
// them stable until its one-cycle done/valid pulse, and drops req in that
// same cycle; a req still high at the end of HOLD is a new request.
module ram1_arbiter #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RAM1_UPPER = 16'h8000,
  parameter logic [15:0]       NOP_INSTR  = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [15:0]       if_instr,
  output logic              if_stall,
  // data memory port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_conflict,
  // SRAM pads
  output logic [17:0]       ram1_addr,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic [15:0]       ram1_dq_o,
  output logic              ram1_dq_oe,
  input  logic [15:0]       ram1_dq_i,
  // debug view of the sequencer state
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              if_valid_q, if_valid_d;
  logic [15:0]       if_instr_q, if_instr_d;
  logic              mem_done_q, mem_done_d;
  logic [15:0]       mem_rdata_q, mem_rdata_d;

  logic mem_elig;
  logic grant_pt;
  logic pick_mem;

  assign mem_elig = mem_req & (mem_addr < RAM1_UPPER);
  assign grant_pt = (state_q == S_IDLE) || (state_q == S_HOLD);

`ifdef RAM1_ARB_FAIR_EN
  owner_t last_owner_q, last_owner_d;

  // On a tie the requester that did not win the previous grant goes first.
  assign pick_mem = mem_elig & (~if_req | (last_owner_q == OWN_IF));

  // Remember who won the most recent grant.
  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_pt && (mem_elig || if_req)) begin
      last_owner_d = pick_mem ? OWN_MEM : OWN_IF;
    end
  end

  // Fairness history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OWN_MEM;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Fixed priority: data accesses always win a tie.
  assign pick_mem = mem_elig;
`endif

  // Next-state and access latching: grants happen in IDLE and at the end of HOLD.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (mem_elig || if_req) begin
          state_d = S_SETUP;
          if (pick_mem) begin
            owner_d = OWN_MEM;
            addr_d  = mem_addr;
            we_d    = mem_we;
            wdata_d = mem_wdata;
          end else begin
            owner_d = OWN_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Data return: read data is captured as SETUP closes, with a one-cycle pulse.
  always_comb begin
    if_valid_d  = (state_q == S_SETUP) && (owner_q == OWN_IF);
    mem_done_d  = (state_q == S_SETUP) && (owner_q == OWN_MEM);
    if_instr_d  = if_valid_d ? ram1_dq_i : NOP_INSTR;
    mem_rdata_d = mem_rdata_q;
    if (mem_done_d && !we_q) begin
      mem_rdata_d = ram1_dq_i;
    end
  end

  // State, latched access and returned data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // SRAM strobes decode straight from state so reset releases them at once.
  // WE is low only in SETUP; write data stays driven through HOLD.
  always_comb begin
    ram1_en    = ~((state_q == S_SETUP) || (state_q == S_HOLD));
    ram1_oe    = ~((state_q == S_SETUP) && !we_q);
    ram1_we    = ~((state_q == S_SETUP) && we_q);
    ram1_dq_oe = ((state_q == S_SETUP) || (state_q == S_HOLD)) && we_q;
    ram1_dq_o  = wdata_q;
    ram1_addr  = 18'(addr_q);
  end

  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_stall     = if_req & ~if_valid_q;
  assign mem_done     = mem_done_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_conflict = mem_elig & if_req;
  assign dbg_state    = state_q;

endmodule
